ycr_tcm_ctrl: RTL

- Tightly-coupled-memory controller that sits directly upstream of the dual-port TCM array.
- Converts the core's IMEM request/response interface onto array port A (read-only).
- Converts the core's DMEM request/response interface onto array port B (read/write with byte enables).
- Performs byte-lane alignment, size and alignment checks, and registers the one-cycle response handshake.

---
 rtl/ycr_memif_pkg.sv | 25 ++
 rtl/ycr_tcm_lane_align.sv | 48 ++++
 rtl/ycr_tcm_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ycr_memif_pkg.sv
// Shared memory-interface types for the core-side IMEM/DMEM ports and TCM
// address-map defaults.
package ycr_memif_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } type_ycr_mem_cmd_e;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HWORD = 2'b01,
        WORD  = 2'b10
    } type_ycr_mem_width_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OKAY  = 2'b01,
        ERROR = 2'b10
    } type_ycr_mem_resp_e;

    localparam logic [31:0] YCR_TCM_BASE_DEF = 32'h0C48_0000;
    localparam logic [31:0] YCR_TCM_SIZE_DEF = 32'h0001_0000;

endpackage

// File: rtl/ycr_tcm_lane_align.sv
// Byte-lane steering between LSB-justified core data and the 32-bit TCM word:
// write side builds the byte mask and replicated lanes, read side right-aligns.
module ycr_tcm_lane_align
    import ycr_memif_pkg::*;
(
    input  logic [1:0]  wr_width,
    input  logic [1:0]  wr_offset,
    input  logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_lanes,
    input  logic [1:0]  rd_width,
    input  logic [1:0]  rd_offset,
    input  logic [31:0] rd_q,
    output logic [31:0] rd_data
);

    logic [31:0] rd_shifted;

    assign rd_shifted = rd_q >> {rd_offset, 3'b000};

    // Replicating the source data across lanes lets the byte mask alone pick
    // the destination, so no data shifter is needed on the write side.
    always_comb begin
        wr_be    = 4'b1111;
        wr_lanes = wr_data;
        case (wr_width)
            BYTE: begin
                wr_be    = 4'b0001 << wr_offset;
                wr_lanes = {4{wr_data[7:0]}};
            end
            HWORD: begin
                wr_be    = 4'b0011 << wr_offset;
                wr_lanes = {2{wr_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_data = rd_shifted;
        case (rd_width)
            BYTE:    rd_data = {24'h0, rd_shifted[7:0]};
            HWORD:   rd_data = {16'h0, rd_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/ycr_tcm_ctrl.sv
// TCM controller: IMEM onto read-only array port A, DMEM onto read/write port B,
// with address/alignment checking and a single registered response stage.
module ycr_tcm_ctrl
    import ycr_memif_pkg::*;
#(
    parameter int          YCR_WIDTH    = 32,
    parameter logic [31:0] YCR_SIZE     = YCR_TCM_SIZE_DEF,
    parameter logic [31:0] YCR_TCM_BASE = YCR_TCM_BASE_DEF,
    parameter int          AW           = $clog2(YCR_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_req,
    input  logic [31:0]          imem_addr,
    output logic                 imem_req_ack,
    output logic [YCR_WIDTH-1:0] imem_rdata,
    output logic [1:0]           imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_cmd,
    input  logic [1:0]           dmem_width,
    input  logic [31:0]          dmem_addr,
    input  logic [YCR_WIDTH-1:0] dmem_wdata,
    output logic                 dmem_req_ack,
    output logic [YCR_WIDTH-1:0] dmem_rdata,
    output logic [1:0]           dmem_resp,
    output logic                 mem_rena,
    output logic [AW-3:0]        mem_addra,
    input  logic [YCR_WIDTH-1:0] mem_qa,
    output logic                 mem_renb,
    output logic                 mem_wenb,
    output logic [3:0]           mem_webb,
    output logic [AW-3:0]        mem_addrb,
    output logic [YCR_WIDTH-1:0] mem_datab,
    input  logic [YCR_WIDTH-1:0] mem_qb
);

    type_ycr_mem_resp_e imem_resp_q, imem_resp_d;
    type_ycr_mem_resp_e dmem_resp_q, dmem_resp_d;
    logic [AW-3:0]      addra_q, addra_d;
    logic [AW-3:0]      addrb_q, addrb_d;
    logic               dmem_rd_q, dmem_rd_d;
    logic [1:0]         dmem_off_q, dmem_off_d;
    logic [1:0]         dmem_width_q, dmem_width_d;

    logic               imem_hit, imem_err;
    logic               dmem_hit, dmem_err, dmem_ok;
    logic [31:0]        rd_aligned;

    assign imem_req_ack = imem_req & ~rst;
    assign dmem_req_ack = dmem_req & ~rst;

    assign imem_hit = (imem_addr[31:AW] == YCR_TCM_BASE[31:AW]);
    assign imem_err = ~imem_hit | (imem_addr[1:0] != 2'b00);
    assign dmem_hit = (dmem_addr[31:AW] == YCR_TCM_BASE[31:AW]);

    always_comb begin
        dmem_err = ~dmem_hit;
        case (dmem_width)
            BYTE:    ;
            HWORD:   if (dmem_addr[0]) dmem_err = 1'b1;
            WORD:    if (dmem_addr[1:0] != 2'b00) dmem_err = 1'b1;
            default: dmem_err = 1'b1;
        endcase
    end

    assign dmem_ok  = dmem_req_ack & ~dmem_err;
    assign mem_rena = imem_req_ack & ~imem_err;
    assign mem_renb = dmem_ok & (dmem_cmd == READ);
    assign mem_wenb = dmem_ok & (dmem_cmd == WRITE);

    // Addresses pass straight through on an access and otherwise hold the
    // last value so the array address pins stay quiet between accesses.
    assign mem_addra = mem_rena ? imem_addr[AW-1:2] : addra_q;
    assign mem_addrb = (mem_renb | mem_wenb) ? dmem_addr[AW-1:2] : addrb_q;

    ycr_tcm_lane_align u_lane_align (
        .wr_width  (dmem_width),
        .wr_offset (dmem_addr[1:0]),
        .wr_data   (dmem_wdata),
        .wr_be     (mem_webb),
        .wr_lanes  (mem_datab),
        .rd_width  (dmem_width_q),
        .rd_offset (dmem_off_q),
        .rd_q      (mem_qb),
        .rd_data   (rd_aligned)
    );

    always_comb begin
        imem_resp_d  = IDLE;
        dmem_resp_d  = IDLE;
        if (imem_req_ack) imem_resp_d = imem_err ? ERROR : OKAY;
        if (dmem_req_ack) dmem_resp_d = dmem_err ? ERROR : OKAY;
        addra_d      = mem_addra;
        addrb_d      = mem_addrb;
        dmem_rd_d    = mem_renb;
        dmem_off_d   = mem_renb ? dmem_addr[1:0] : dmem_off_q;
        dmem_width_d = mem_renb ? dmem_width     : dmem_width_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_resp_q  <= IDLE;
            dmem_resp_q  <= IDLE;
            addra_q      <= '0;
            addrb_q      <= '0;
            dmem_rd_q    <= 1'b0;
            dmem_off_q   <= 2'b00;
            dmem_width_q <= 2'b00;
        end else begin
            imem_resp_q  <= imem_resp_d;
            dmem_resp_q  <= dmem_resp_d;
            addra_q      <= addra_d;
            addrb_q      <= addrb_d;
            dmem_rd_q    <= dmem_rd_d;
            dmem_off_q   <= dmem_off_d;
            dmem_width_q <= dmem_width_d;
        end
    end

    // Reset masks a response still sitting in the register stage.
    assign imem_resp  = rst ? IDLE : imem_resp_q;
    assign dmem_resp  = rst ? IDLE : dmem_resp_q;
    assign imem_rdata = (~rst && imem_resp_q == OKAY) ? mem_qa : '0;
    assign dmem_rdata = (~rst && dmem_rd_q) ? rd_aligned : '0;

endmodule
